// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Stores to TXDATA fill a byte FIFO that a bit-timed FSM serializes onto uart_txd.
module dmem_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic [31:0] bus_rdata,
  output logic        uart_txd,
  output logic        irq_tx_empty
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_next;
  logic          overflow_r;
  logic [15:0]   baud_div_r, baud_wr_s, baud_next;
  logic [15:0]   bit_div_r, bit_div_next, bit_cnt_r, cnt_next;
  logic [2:0]    bit_idx_r, idx_next;
  logic [7:0]    shift_r, shift_next;
  state_t        state_r, state_next;
  logic          txd_r, txd_next, irq_r, irq_next;
  logic          pop_s, bit_end_s;

  logic wr_s, sel_tx_s, sel_status_s, sel_baud_s;
  logic push_req_s, push_ok_s, drop_s, ovf_clr_s;
  logic [31:0] count_ext_s;
  logic [3:0]  count_sat_s;
  logic        unused_bits_s;

  assign wr_s         = bus_valid && bus_we;
  assign sel_tx_s     = (bus_addr[3:2] == 2'd0);
  assign sel_status_s = (bus_addr[3:2] == 2'd1);
  assign sel_baud_s   = (bus_addr[3:2] == 2'd2);
  assign push_req_s   = wr_s && sel_tx_s && bus_wstrb[0];
  assign push_ok_s    = push_req_s && (count_r < DEPTH_C);
  assign drop_s       = push_req_s && !push_ok_s;
  assign ovf_clr_s    = wr_s && sel_status_s && bus_wstrb[0] && bus_wdata[3];
  assign bit_end_s    = (bit_cnt_r == (bit_div_r - 16'd1));
  assign count_ext_s  = 32'(count_r);
  assign count_sat_s  = (count_ext_s > 32'd15) ? 4'd15 : count_ext_s[3:0];
  assign unused_bits_s = ^{bus_addr[1:0], bus_wdata[31:16], bus_wstrb[3:2]};

  assign uart_txd     = txd_r;
  assign irq_tx_empty = irq_r;

  // Combinational read mux; a zero divider is never stored so the bit timer cannot stall.
  always_comb begin
    bus_rdata = 32'd0;
    case (bus_addr[3:2])
      2'd1:    bus_rdata = {24'd0, count_sat_s, overflow_r, (count_r == {(AW+1){1'b0}}),
                            (count_r == DEPTH_C), (state_r != IDLE)};
      2'd2:    bus_rdata = {16'd0, baud_div_r};
      default: bus_rdata = 32'd0;
    endcase
  end

  // Byte-lane merge of a BAUDDIV write.
  always_comb begin
    baud_wr_s = baud_div_r;
    if (wr_s && sel_baud_s) begin
      if (bus_wstrb[0]) baud_wr_s[7:0] = bus_wdata[7:0];
      else              baud_wr_s[7:0] = baud_div_r[7:0];
      if (bus_wstrb[1]) baud_wr_s[15:8] = bus_wdata[15:8];
      else              baud_wr_s[15:8] = baud_div_r[15:8];
    end else begin
      baud_wr_s = baud_div_r;
    end
    baud_next = (baud_wr_s == 16'd0) ? 16'd1 : baud_wr_s;
  end

  // Transmit FSM next state; STOP pops directly into START to avoid an idle gap.
  always_comb begin
    state_next   = state_r;
    pop_s        = 1'b0;
    cnt_next     = bit_cnt_r;
    idx_next     = bit_idx_r;
    shift_next   = shift_r;
    bit_div_next = bit_div_r;
    case (state_r)
      IDLE: begin
        if (count_r != {(AW+1){1'b0}}) begin
          pop_s        = 1'b1;
          shift_next   = fifo_mem[rd_ptr_r];
          bit_div_next = baud_div_r;
          cnt_next     = 16'd0;
          state_next   = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_next   = 16'd0;
          idx_next   = 3'd0;
          state_next = DATA;
        end else begin
          cnt_next = bit_cnt_r + 16'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_next   = 16'd0;
          shift_next = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) state_next = STOP;
          else                   idx_next = bit_idx_r + 3'd1;
        end else begin
          cnt_next = bit_cnt_r + 16'd1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_next = 16'd0;
          if (count_r != {(AW+1){1'b0}}) begin
            pop_s        = 1'b1;
            shift_next   = fifo_mem[rd_ptr_r];
            bit_div_next = baud_div_r;
            state_next   = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = bit_cnt_r + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase

    case ({push_ok_s, pop_s})
      2'b10:   count_next = count_r + (AW+1)'(1);
      2'b01:   count_next = count_r - (AW+1)'(1);
      default: count_next = count_r;
    endcase
    irq_next = (count_next == {(AW+1){1'b0}}) && (state_next == IDLE);
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) fifo_mem[wr_ptr_r] <= bus_wdata[7:0];
  end

  // State, counters, registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      baud_div_r <= DIV_RST;
      bit_div_r  <= DIV_RST;
      bit_cnt_r  <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      txd_r      <= 1'b1;
      irq_r      <= 1'b1;
    end else begin
      state_r    <= state_next;
      wr_ptr_r   <= push_ok_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r   <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      count_r    <= count_next;
      overflow_r <= drop_s ? 1'b1 : (ovf_clr_s ? 1'b0 : overflow_r);
      baud_div_r <= baud_next;
      bit_div_r  <= bit_div_next;
      bit_cnt_r  <= cnt_next;
      bit_idx_r  <= idx_next;
      shift_r    <= shift_next;
      txd_r      <= txd_next;
      irq_r      <= irq_next;
    end
  end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Scoreboard bench for dmem_uart_tx: stimulus queues expected frames, a line
// monitor decodes uart_txd cycle by cycle and compares against them.
module tb_dmem_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid, bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        uart_txd, irq_tx_empty;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         gap;   // required idle cycles before start bit, -1 = any
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     mon_busy = 1'b0;
  localparam int LIMIT = 20000;

  dmem_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(868)) dut (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata), .uart_txd(uart_txd), .irq_tx_empty(irq_tx_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Call just after a negedge; returns just after the following negedge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d; bus_wstrb = s;
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string name);
    bus_we = 1'b0; bus_addr = a;
    #1;
    check(name, bus_rdata, exp);
  endtask

  task automatic push_exp(input logic [7:0] d, input int div, input int gap);
    frame_t f;
    f.data = d; f.div = div; f.gap = gap;
    exp_q.push_back(f);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    bit pending;
    do begin
      @(negedge clk);
      n++;
      pending = (exp_q.size() != 0) || mon_busy;
    end while (pending && n < LIMIT);
    check({name, "_drained"}, {31'd0, pending}, 32'd0);
    @(negedge clk);
    check({name, "_irq"}, {31'd0, irq_tx_empty}, 32'd1);
    check({name, "_txd_idle"}, {31'd0, uart_txd}, 32'd1);
  endtask

  // Line monitor: for each expected frame, find the start bit and compare every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        frame_t f;
        int gap, mism;
        logic [9:0] bits;
        mon_busy = 1'b1;
        f = exp_q.pop_front();
        bits = {1'b1, f.data, 1'b0};
        gap = 0;
        while (uart_txd === 1'b1 && gap < LIMIT) begin
          @(negedge clk);
          gap++;
        end
        if (uart_txd !== 1'b0) begin
          check($sformatf("start_timeout_%02h", f.data), {31'd0, uart_txd}, 32'd0);
        end else begin
          if (f.gap >= 0) check($sformatf("gap_%02h", f.data), gap, f.gap);
          mism = 0;
          for (int k = 0; k < 10 * f.div; k++) begin
            if (k > 0) @(negedge clk);
            if (uart_txd !== bits[k / f.div]) mism++;
          end
          check($sformatf("frame_%02h_div%0d_bad_cycles", f.data, f.div), mism, 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0;
    bus_addr = 4'd0; bus_wdata = 32'd0; bus_wstrb = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_irq", {31'd0, irq_tx_empty}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rd_check(4'h4, 32'h0000_0004, "rst_status");
    rd_check(4'h8, 32'd868, "rst_bauddiv");
    rd_check(4'h0, 32'd0, "txdata_reads_zero");
    rd_check(4'hC, 32'd0, "reserved_reads_zero");

    // Single 0xA5 frame at div 4, with start-bit latency check.
    @(negedge clk);
    wr(4'h8, 32'd4, 4'b0011);
    push_exp(8'hA5, 4, -1);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'hA5; bus_wstrb = 4'b0001;
    @(posedge clk);
    #1;
    bus_valid = 1'b0; bus_we = 1'b0;
    check("txd_high_at_push_edge", {31'd0, uart_txd}, 32'd1);
    @(posedge clk);
    #1;
    check("txd_low_one_cycle_after_push", {31'd0, uart_txd}, 32'd0);
    check("irq_low_in_frame", {31'd0, irq_tx_empty}, 32'd0);
    @(negedge clk);
    wait_idle("a5");

    // Three back-to-back frames at div 2.
    wr(4'h8, 32'd2, 4'b0011);
    push_exp(8'h01, 2, -1);
    push_exp(8'h02, 2, 0);
    push_exp(8'h03, 2, 0);
    wr(4'h0, 32'h01, 4'b0001);
    wr(4'h0, 32'h02, 4'b0001);
    wr(4'h0, 32'h03, 4'b0001);
    rd_check(4'h4, 32'h0000_0021, "status_count2_busy");
    wait_idle("b2b");

    // Zero divider and mid-frame divider change.
    wr(4'h8, 32'd0, 4'b0011);
    rd_check(4'h8, 32'd1, "bauddiv_zero_as_one");
    wr(4'h8, 32'd3, 4'b0011);
    push_exp(8'h3C, 3, -1);
    push_exp(8'hC3, 6, 0);
    wr(4'h0, 32'h3C, 4'b0001);
    repeat (4) @(negedge clk);
    wr(4'h8, 32'd6, 4'b0011);
    rd_check(4'h8, 32'd6, "bauddiv_readback6");
    wr(4'h0, 32'hC3, 4'b0001);
    wait_idle("divchg");

    // Overflow at div 1000: ten pushes, first popped, eight queued, tenth dropped.
    wr(4'h8, 32'd1000, 4'b0011);
    for (int i = 0; i < 10; i++) wr(4'h0, (i == 0) ? 32'h00 : 32'h10 + i, 4'b0001);
    rd_check(4'h4, 32'h0000_008B, "status_full_overflow");
    wr(4'h4, 32'h8, 4'b0000);
    rd_check(4'h4, 32'h0000_008B, "ovf_clear_needs_strb");
    wr(4'h4, 32'h8, 4'b0001);
    rd_check(4'h4, 32'h0000_0083, "status_overflow_cleared");

    // Asynchronous reset in the middle of the data bits.
    repeat (1200) @(negedge clk);
    check("txd_low_in_data", {31'd0, uart_txd}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_txd", {31'd0, uart_txd}, 32'd1);
    check("async_rst_irq", {31'd0, irq_tx_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check(4'h4, 32'h0000_0004, "post_rst_status");
    rd_check(4'h8, 32'd868, "post_rst_bauddiv");
    repeat (20) @(negedge clk);
    check("post_rst_txd_idle", {31'd0, uart_txd}, 32'd1);
    rd_check(4'h4, 32'h0000_0004, "post_rst_fifo_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
